fsic_io_tx_gearbox: RTL and testbench
=====================================

// Module: fsic_io_tx_gearbox
// PURPOSE
//  Transmit-side 2:1 gearbox of the io_serdes path, clocked by clk_div2 from the
//  clock divider. Buffers 2*LANE_W-bit words from the core side in a small FIFO.
//  Emits each word as two LANE_W-bit beats on consecutive clk_div2 cycles, in
//  lockstep with the divided (div4) frame phase.
//  Tracks the phase_ref toggle and drops to re-align on any phase violation.
// PARAMETERS
//  LANE_W    8        serial-side beat width (bits); word width = 2*LANE_W
//  DEPTH     4        FIFO entries (power of 2, >=2)
//  IDLE_PAT  8'hA5    beat value driven when no word is in flight (LANE_W bits)
// PORTS
//  clk_div2   in   1         gearbox clock (rising edge)
//  resetb     in   1         reset, asynchronous, active-low
//  phase_ref  in   1         frame phase from div4 domain; must toggle every clk_div2 cycle
//  in_valid   in   1         input word valid
//  in_data    in   2*LANE_W  input word; [LANE_W-1:0] is sent first
//  in_ready   out  1         FIFO can accept a word (combinational: count<DEPTH)
//  ser_data   out  LANE_W    serial-side beat (registered)
//  ser_valid  out  1         ser_data carries payload (registered)
//  ser_first  out  1         ser_data is the low half of a word (registered)
//  locked     out  1         1 in state RUN
//  phase_err  out  1         sticky: a phase violation occurred since reset
//  drop_cnt   out  8         aborted in-flight words, saturates at 8'hFF
// BEHAVIOUR
//  Reset (resetb=0, async): state=ALIGN, FIFO empty (count=0), ph_q=0, slot=0.
//   ser_data=IDLE_PAT, ser_valid=0, ser_first=0, phase_err=0, drop_cnt=0.
//  ph_q <= phase_ref every cycle.
//  Push: in_valid & in_ready. No push when full, even if a pop occurs that cycle.
//  FSM ALIGN: outputs idle (IDLE_PAT, valid=0). Stays until ph_q==0 & phase_ref==1.
//   That edge -> RUN with slot=0. No pop occurs on the transition edge.
//  FSM RUN: slot toggles every cycle.
//   Check each cycle: if phase_ref==ph_q -> violation:
//    state<=ALIGN, phase_err<=1, outputs idle next edge.
//    If slot==1 (a low half was already sent), drop_cnt++ (saturating) and the
//    popped word is discarded. FIFO contents are untouched.
//   slot 0, FIFO non-empty: pop head into hold reg.
//    ser_data<=head[LANE_W-1:0], ser_valid<=1, ser_first<=1.
//   slot 0, FIFO empty: ser_data<=IDLE_PAT, ser_valid<=0, ser_first<=0.
//    The slot-1 beat is also idle.
//   slot 1 after pop: ser_data<=hold[2*LANE_W-1:LANE_W], ser_valid<=1, ser_first<=0.
//  A word never splits across a gap: pops occur only at slot 0.
//  Latency: a word pushed at edge t into an empty FIFO, with slot==0 at t+1, has its
//   low half on ser_data after edge t+1 and its high half after edge t+2.
//  Pointers wrap modulo DEPTH. count is sized $clog2(DEPTH)+1 bits.
//  Simultaneous push+pop (not full): count unchanged, order preserved.
//  Reset mid-word: word is lost and the FIFO is emptied; no drop_cnt increment.
//  locked = (state==RUN). phase_err clears only on reset.
// TESTING
//  1 Reset; phase_ref toggling; push 16'h1234 -> locked after first 0->1 edge;
//    beats 8'h34 (first=1), 8'h12 (first=0), then IDLE_PAT with valid=0.
//  2 Push 5 words back-to-back into an unlocked gearbox -> in_ready=0 after 4th;
//    5th held. Once locked, beats appear in order with no idle gaps.
//  3 Empty FIFO while locked -> ser_data=8'hA5, ser_valid=0 continuously.
//    A word pushed mid-slot-1 starts at the next slot 0.
//  4 Hold phase_ref static 2 cycles right after a low-half beat -> phase_err=1,
//    locked=0, drop_cnt=1, no high half sent; relock resumes with the next FIFO word.
//  5 Assert resetb=0 mid-word with 3 words queued -> outputs idle at once,
//    in_ready=1, drop_cnt=0; the next push is the first word sent.
//  6 Force 300 phase violations each in slot 1 -> drop_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/fsic_io_tx_gearbox.sv
// fsic_io_tx_gearbox: buffers 2*LANE_W-bit words and emits each as two phase-locked LANE_W-bit beats
module fsic_io_tx_gearbox #(
  parameter int LANE_W = 8,
  parameter int DEPTH = 4,
  parameter logic [LANE_W-1:0] IDLE_PAT = 8'hA5
) (
  input  logic                clk_div2,
  input  logic                resetb,
  input  logic                phase_ref,
  input  logic                in_valid,
  input  logic [2*LANE_W-1:0] in_data,
  output logic                in_ready,
  output logic [LANE_W-1:0]   ser_data,
  output logic                ser_valid,
  output logic                ser_first,
  output logic                locked,
  output logic                phase_err,
  output logic [7:0]          drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {ALIGN, RUN} state_t;
  state_t state, state_nx;
  logic [2*LANE_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [LANE_W-1:0] hold;
  logic ph_q, slot, busy, viol, push, pop;
  // DEPTH is a power of two, so count<DEPTH is just the clear MSB
  assign in_ready = !count[AW];
  assign push = in_valid && in_ready;
  assign viol = state == RUN && phase_ref == ph_q;
  assign pop = state == RUN && !slot && !viol && count != '0;
  always_ff @(posedge clk_div2 or negedge resetb)
    if (!resetb) state <= ALIGN;
    else state <= state_nx;
  always_comb state_nx = state == ALIGN ? (!ph_q && phase_ref ? RUN : ALIGN) : (viol ? ALIGN : RUN);
  always_comb locked = state == RUN;
  always_ff @(posedge clk_div2) if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk_div2 or negedge resetb)
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  // busy marks a word whose low half went out and whose high half is owed next cycle
  always_ff @(posedge clk_div2 or negedge resetb)
    if (!resetb) begin
      ph_q <= 1'b0;
      slot <= 1'b0;
      busy <= 1'b0;
      hold <= '0;
      ser_data <= IDLE_PAT;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      phase_err <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      ph_q <= phase_ref;
      slot <= state == RUN && !viol && !slot;
      busy <= pop;
      if (pop) hold <= mem[rd_ptr][2*LANE_W-1:LANE_W];
      ser_data <= pop ? mem[rd_ptr][LANE_W-1:0] : (busy && !viol ? hold : IDLE_PAT);
      ser_valid <= pop || (busy && !viol);
      ser_first <= pop;
      if (viol) phase_err <= 1'b1;
      if (viol && busy && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
endmodule

// File: tb/tb_fsic_io_tx_gearbox.sv
// tb_fsic_io_tx_gearbox: directed and random stimulus checked against a queue-based gearbox model
module tb_fsic_io_tx_gearbox;
  localparam int DEPTH = 4;
  localparam logic [7:0] IDLE = 8'hA5;
  logic clk_div2 = 0, resetb = 1, phase_ref = 0, in_valid = 0;
  logic [15:0] in_data = '0;
  logic in_ready, ser_valid, ser_first, locked, phase_err;
  logic [7:0] ser_data, drop_cnt;
  int n_cmp = 0, n_bad = 0;
  bit hold_ph = 0, rnd_data = 0;
  logic [15:0] q[$];
  bit m_run, m_slot, m_busy, m_ph;
  logic [7:0] m_hi, e_data, e_drop;
  bit e_valid, e_first, e_err;

  fsic_io_tx_gearbox #(.LANE_W(8), .DEPTH(DEPTH), .IDLE_PAT(IDLE)) dut (
    .clk_div2(clk_div2), .resetb(resetb), .phase_ref(phase_ref), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .ser_data(ser_data), .ser_valid(ser_valid),
    .ser_first(ser_first), .locked(locked), .phase_err(phase_err), .drop_cnt(drop_cnt)
  );

  always #5 clk_div2 = ~clk_div2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: state after the last edge is checked at negedge, then advanced with the inputs the next edge samples
  always @(negedge clk_div2) begin
    bit push, viol;
    logic [15:0] w;
    if (!resetb) begin
      q.delete();
      m_run = 0; m_slot = 0; m_busy = 0; m_ph = 0;
      e_data = IDLE; e_valid = 0; e_first = 0; e_err = 0; e_drop = 0;
    end
    chk("ser_data", ser_data, e_data);
    chk("ser_valid", ser_valid, e_valid);
    chk("ser_first", ser_first, e_first);
    chk("locked", locked, m_run);
    chk("phase_err", phase_err, e_err);
    chk("drop_cnt", drop_cnt, e_drop);
    chk("in_ready", in_ready, q.size() < DEPTH);
    if (resetb) begin
      push = in_valid && q.size() < DEPTH;
      viol = m_run && phase_ref == m_ph;
      e_data = IDLE; e_valid = 0; e_first = 0;
      if (!m_run) begin
        m_run = !m_ph && phase_ref;
        m_slot = 0; m_busy = 0;
      end else if (viol) begin
        if (m_busy && e_drop != 8'hFF) e_drop = e_drop + 8'd1;
        e_err = 1; m_run = 0; m_slot = 0; m_busy = 0;
      end else if (!m_slot) begin
        if (q.size() != 0) begin
          w = q.pop_front();
          e_data = w[7:0]; e_valid = 1; e_first = 1; m_hi = w[15:8]; m_busy = 1;
        end
        m_slot = 1;
      end else begin
        if (m_busy) begin e_data = m_hi; e_valid = 1; end
        m_busy = 0; m_slot = 0;
      end
      if (push) q.push_back(in_data);
      m_ph = phase_ref;
    end
  end

  task automatic cyc(input bit stall = 0);
    if (!(stall || hold_ph)) phase_ref = ~phase_ref;
    if (rnd_data) in_data = 16'($urandom);
    @(posedge clk_div2);
    #1;
  endtask

  task automatic do_reset();
    resetb = 0; phase_ref = 0; hold_ph = 1; in_valid = 0; rnd_data = 0;
    cyc(); cyc();
    resetb = 1;
  endtask

  task automatic push_word(input logic [15:0] w);
    bit acc;
    acc = 0;
    in_valid = 1; in_data = w;
    for (int i = 0; i < 32 && !acc; i++) begin
      acc = in_ready;
      cyc();
    end
    in_valid = 0;
    chk("push_accept", acc, 1);
  endtask

  task automatic wait_beat(input bit want_first);
    for (int i = 0; i < 24 && !(ser_valid && (ser_first || !want_first)); i++) cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, done, stall;
    int run;
    #1 do_reset();
    // 1: single word after lock
    hold_ph = 0;
    push_word(16'h1234);
    wait_beat(1);
    chk("t1_lo", ser_data, 8'h34); chk("t1_lo_first", ser_first, 1); chk("t1_locked", locked, 1);
    cyc();
    chk("t1_hi", ser_data, 8'h12); chk("t1_hi_first", ser_first, 0); chk("t1_hi_valid", ser_valid, 1);
    cyc();
    chk("t1_idle", ser_data, IDLE); chk("t1_idle_valid", ser_valid, 0);
    // 2: fill while unaligned, fifth word held, then gapless drain
    do_reset();
    push_word(16'h2211); push_word(16'h4433); push_word(16'h6655); push_word(16'h8877);
    chk("t2_full", in_ready, 0);
    in_valid = 1; in_data = 16'hAA99;
    cyc();
    chk("t2_held", in_ready, 0);
    hold_ph = 0; run = 0; done = 0;
    for (int i = 0; i < 24; i++) begin
      acc = in_ready;
      cyc();
      if (acc) in_valid = 0;
      if (ser_valid && !done) run++;
      else if (run > 0) done = 1;
    end
    in_valid = 0;
    chk("t2_gapless", run, 10);
    // 3: idle while locked, push during slot 1
    for (int i = 0; i < 6; i++) begin
      chk("t3_idle_data", ser_data, IDLE); chk("t3_idle_valid", ser_valid, 0);
      cyc();
    end
    for (int i = 0; i < 4 && !m_slot; i++) cyc();
    in_valid = 1; in_data = 16'h5A3C;
    cyc();
    in_valid = 0;
    cyc();
    chk("t3_lo", ser_data, 8'h3C); chk("t3_lo_first", ser_first, 1);
    cyc();
    chk("t3_hi", ser_data, 8'h5A); chk("t3_hi_valid", ser_valid, 1);
    // 4: phase violation right after a low half
    in_valid = 1; in_data = 16'hC3D2;
    cyc();
    in_data = 16'hE1F0;
    cyc();
    in_valid = 0;
    for (int i = 0; i < 24 && !(ser_first && ser_data == 8'hD2); i++) cyc();
    chk("t4_lo", ser_data, 8'hD2);
    cyc(1); cyc(1);
    chk("t4_err", phase_err, 1); chk("t4_locked", locked, 0);
    chk("t4_drop", drop_cnt, 1); chk("t4_valid", ser_valid, 0);
    wait_beat(0);
    chk("t4_resume", ser_data, 8'hF0); chk("t4_resume_first", ser_first, 1);
    // 5: reset mid-word with words queued
    do_reset();
    push_word(16'h0B0A); push_word(16'h0D0C); push_word(16'h0F0E); push_word(16'h1110);
    hold_ph = 0;
    wait_beat(1);
    chk("t5_lo", ser_data, 8'h0A);
    resetb = 0;
    #1;
    chk("t5_valid", ser_valid, 0); chk("t5_data", ser_data, IDLE);
    chk("t5_ready", in_ready, 1); chk("t5_drop", drop_cnt, 0); chk("t5_locked", locked, 0);
    phase_ref = 0; hold_ph = 1;
    cyc(); cyc();
    resetb = 1; hold_ph = 0;
    push_word(16'hBEEF);
    wait_beat(1);
    chk("t5_next", ser_data, 8'hEF);
    // 6: drop counter saturation
    do_reset();
    hold_ph = 0; in_valid = 1; rnd_data = 1;
    for (int k = 0; k < 300; k++) begin
      wait_beat(1);
      chk("t6_first", ser_first, 1);
      cyc(1);
    end
    in_valid = 0; rnd_data = 0;
    chk("t6_sat", drop_cnt, 8'hFF);
    // random traffic with occasional violations outside the empty-slot-1 case
    do_reset();
    hold_ph = 0;
    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_data = 16'($urandom);
      stall = $urandom_range(0, 19) == 0 && (!m_run || !m_slot || m_busy);
      cyc(stall);
    end
    in_valid = 0;
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
